chan_mux_rr: RTL and testbench
==============================

# chan_mux_rr

Parametrised N-channel, W-bit registered selector: the sequential successor of the gate-level 8:1 mux. It chooses one input channel per transfer, either by an explicit select or by round-robin among requesting channels, and presents the word in an output register with a valid/ready handshake. It sits between the ALU operand sources and the ALU input stage, replacing the fixed combinational operand muxes.

## Interface
- W, 8, data width per channel (≥1)
- N, 8, channel count (2..32, need not be a power of two)
- SW, $clog2(N), select/channel-id width (derived, do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- in_data  in  N*W  channel c occupies bits [c*W +: W]
- in_valid  in  N  per-channel request
- in_ready  out  N  per-channel accept, one-hot or zero
- mode  in  1  0 = MODE_FIXED (use sel), 1 = MODE_RR (round-robin)
- sel  in  SW  channel index in MODE_FIXED
- out_data  out  W  registered selected word
- out_chan  out  SW  index of channel that supplied out_data
- out_valid  out  1  output register holds a word
- out_ready  in  1  downstream accept

## Operation
- Two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = !out_valid | out_ready. Load is allowed in EMPTY, or in FULL during the same cycle the held word drains.
- Grant (combinational, one channel max):
  - MODE_FIXED: g = sel, granted only if sel < N and in_valid[sel].
  - MODE_RR: g = first c with in_valid[c], scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
- in_ready[g] = can_load & grant_found; all other bits 0. in_ready never depends on out_valid alone when out_ready=1.
- On a transfer (in_valid[g] & in_ready[g]): out_data <= in_data[g], out_chan <= g, out_valid <= 1.
- No transfer while draining (out_valid & out_ready & no grant): out_valid <= 0, out_data/out_chan hold.
- FULL & !out_ready: all registers hold and in_ready = 0.
- ptr (SW bits, internal): on every transfer in either mode, ptr <= (g == N-1) ? 0 : g+1. Unchanged otherwise. The wrap is modulo N, not 2^SW.
- A mode or sel change takes effect at the next grant evaluation. A word already held is unaffected, and ptr is retained across mode changes.
- sel ≥ N (non-power-of-two N): no grant, in_ready = 0, and no error flag.

## Timing
- Latency is 1 cycle from the input handshake to out_valid/out_data.
- Throughput is one word per cycle when out_ready is held high.
- Reset (rst_n=0 at a clk edge) sets out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is forced to 0 while rst_n=0.
- Reset mid-transfer: the held word is discarded with no drain, and any input handshake in that cycle is not accepted.
- in_data/in_valid are sampled only at the transfer edge. Inputs may change freely when in_ready=0.
- Simultaneous drain and load: the new word replaces the old one in the same edge, and out_valid stays 1.
- No combinational path from in_data to out_data. The only combinational paths are in_valid/mode/sel/out_ready → in_ready.

## Structure
- Package chan_mux_pkg holds MODE_FIXED=1'b0, MODE_RR=1'b1, and a function for next-pointer wrap (modulo N).
- Sub-module rr_pick (N, SW): inputs req[N], ptr; outputs found, idx. It is purely combinational rotate/priority logic, reused by other arbiters.
- The top level holds the output register, the ptr register, the mode mux for grant, and the in_ready decode.

## Test plan
- Reset with all in_valid=1: out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset. After release, first RR grant is channel 0.
- MODE_FIXED, sel=5, in_valid=8'hFF, in_data channel5=8'hA5, out_ready=1: in_ready=8'h20, next cycle out_data=A5, out_chan=5. With sel=5 and in_valid[5]=0: in_ready=0 and out_valid falls.
- MODE_RR, in_valid=8'b1010_0100, out_ready=1: grants 2,5,7,2,5 on consecutive cycles. ptr wraps 7→0.
- Backpressure: out_ready=0 for 3 cycles while FULL. out_data holds, in_ready=0, and no word is lost or duplicated. A scoreboard over 1000 random cycles matches input transfers to outputs in order.
- N=5 build: sel=6 gives no grant. RR with all valid gives 0,1,2,3,4,0 (ptr never reaches 5–7).
- Reset asserted while FULL with out_ready=0: next cycle out_valid=0. A later RR grant starts from channel 0.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared mode encodings, output-register state and pointer arithmetic for the
// registered channel selector and its round-robin arbiter.
package chan_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    // Pointer successor that wraps at the channel count, not at a power of two.
    function automatic int next_ptr(input int g, input int n);
        return (g >= n - 1) ? 0 : g + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first asserted request at or after ptr, wrapping
// modulo N. Purely combinational so other arbiters can reuse it.
import chan_mux_pkg::*;

module rr_pick #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx
);

    always_comb begin : pick
        int c;
        // NOTE: every output gets a default before the loop, so no path
        // through the block leaves it unassigned and infers a latch.
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int k = 0; k < N; k++) begin
            c = int'(ptr) + k;
            if (c >= N) begin
                c = c - N;
            end
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = SW'(c);
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N-channel registered selector: explicit-select or round-robin grant feeding a
// one-word output register with a valid/ready handshake.
import chan_mux_pkg::*;

module chan_mux_rr #(
    parameter int W  = 8,
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    input  logic          mode,
    input  logic [SW-1:0] sel,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_chan,
    output logic          out_valid,
    input  logic          out_ready
);

    out_state_t    state;
    out_state_t    next_state;
    logic [SW-1:0] ptr;
    logic          rr_found;
    logic [SW-1:0] rr_idx;
    logic          fix_found;
    logic          grant_found;
    logic [SW-1:0] grant_idx;
    logic          can_load;
    logic          transfer;

    rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // A select beyond the last channel matches no index and so never grants.
    always_comb begin
        fix_found = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (sel == SW'(c) && in_valid[c]) begin
                fix_found = 1'b1;
            end
        end
    end

    assign grant_found = (mode == MODE_RR) ? rr_found : fix_found;
    assign grant_idx   = (mode == MODE_RR) ? rr_idx   : sel;
    assign out_valid   = (state == ST_FULL);
    assign can_load    = !out_valid || out_ready;
    assign transfer    = rst_n && can_load && grant_found;
    assign in_ready    = transfer ? (N'(1) << grant_idx) : '0;

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (transfer)               next_state = ST_FULL;
            ST_FULL:  if (out_ready && !transfer) next_state = ST_EMPTY;
            default:                              next_state = ST_EMPTY;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_chan <= '0;
            ptr      <= '0;
        end else if (transfer) begin
            out_data <= in_data[int'(grant_idx)*W +: W];
            out_chan <= grant_idx;
            ptr      <= SW'(next_ptr(int'(grant_idx), N));
        end
    end

endmodule

// File: tb/tb_chan_mux_rr.sv
// Scoreboard bench for chan_mux_rr: a spec-level model predicts grants and
// queues expected words; a monitor pops them on each output handshake.
import chan_mux_pkg::*;

module tb_chan_mux_rr;

    localparam int W  = 8;
    localparam int N  = 8;
    localparam int SW = $clog2(N);

    typedef struct packed {
        logic [W-1:0]  data;
        logic [SW-1:0] chan;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           mode = MODE_FIXED;
    logic [SW-1:0]  sel = '0;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready = 1'b0;

    logic           rst5_n = 1'b0;
    logic [5*W-1:0] in_data5 = '0;
    logic [4:0]     in_valid5 = '0;
    logic [4:0]     in_ready5;
    logic           mode5 = MODE_FIXED;
    logic [2:0]     sel5 = '0;
    logic [W-1:0]   out_data5;
    logic [2:0]     out_chan5;
    logic           out_valid5;
    logic           out_ready5 = 1'b1;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    bit   m_full = 1'b0;
    int   m_ptr  = 0;

    always #5 clk = ~clk;

    chan_mux_rr #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    chan_mux_rr #(.W(W), .N(5)) dut5 (
        .clk       (clk),
        .rst_n     (rst5_n),
        .in_data   (in_data5),
        .in_valid  (in_valid5),
        .in_ready  (in_ready5),
        .mode      (mode5),
        .sel       (sel5),
        .out_data  (out_data5),
        .out_chan  (out_chan5),
        .out_valid (out_valid5),
        .out_ready (out_ready5)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Grant rule stated directly: fixed uses sel if legal and requesting;
    // round-robin takes the first requester scanning upward from m_ptr mod N.
    function automatic void model_grant(input logic m, input logic [SW-1:0] s,
                                        input logic [N-1:0] v,
                                        output bit found, output int g);
        found = 1'b0;
        g     = 0;
        if (m == MODE_FIXED) begin
            if (int'(s) < N && v[s]) begin
                found = 1'b1;
                g     = int'(s);
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    g     = (m_ptr + k) % N;
                end
            end
        end
    endfunction

    // One clock of stimulus: drive at the falling edge, check in_ready, then
    // advance the model to what the coming rising edge should do.
    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic m, input logic [SW-1:0] s, input logic ordy);
        bit   found;
        int   g;
        logic [N-1:0] exp_ready;
        exp_t e;
        @(negedge clk);
        check("out_valid", out_valid, m_full);
        rst_n     = r;
        in_valid  = v;
        in_data   = d;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        #1;
        model_grant(m, s, v, found, g);
        exp_ready = '0;
        if (r && (!m_full || ordy) && found) begin
            exp_ready[g] = 1'b1;
        end
        check("in_ready", in_ready, exp_ready);
        if (!r) begin
            exp_q.delete();
            m_full = 1'b0;
            m_ptr  = 0;
        end else if ((!m_full || ordy) && found) begin
            e.data = d[g*W +: W];
            e.chan = SW'(g);
            exp_q.push_back(e);
            m_ptr  = (g + 1) % N;
            m_full = 1'b1;
        end else if (m_full && ordy) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: every accepted output word must be the oldest expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got data %0h chan %0d, expected no word", out_data, out_chan);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_chan", out_chan, e.chan);
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] d;
        logic [W-1:0]   held;

        // Reset with every channel requesting.
        d = {$urandom, $urandom};
        step(1'b0, '1, d, MODE_RR, '0, 1'b1);
        step(1'b0, '1, d, MODE_RR, '0, 1'b1);
        check("rst_out_data", out_data, 0);
        check("rst_out_chan", out_chan, 0);
        step(1'b1, '1, d, MODE_RR, '0, 1'b1);
        check("first_rr_grant", in_ready, 8'h01);

        // Fixed select of channel 5, then channel 5 stops requesting.
        d = {$urandom, $urandom};
        d[5*W +: W] = 8'hA5;
        step(1'b1, 8'hFF, d, MODE_FIXED, 3'd5, 1'b1);
        check("fixed_ready", in_ready, 8'h20);
        step(1'b1, 8'hDF, d, MODE_FIXED, 3'd5, 1'b1);
        check("fixed_data", out_data, 8'hA5);
        check("fixed_chan", out_chan, 5);
        check("fixed_no_req", in_ready, 8'h00);
        step(1'b1, 8'hDF, d, MODE_FIXED, 3'd5, 1'b1);
        check("fixed_drained", out_valid, 1'b0);

        // Round-robin over channels 2, 5, 7 from a fresh pointer.
        step(1'b0, '0, d, MODE_RR, '0, 1'b1);
        step(1'b1, 8'hA4, d, MODE_RR, '0, 1'b1);
        check("rr_g0", in_ready, 8'h04);
        step(1'b1, 8'hA4, d, MODE_RR, '0, 1'b1);
        check("rr_g1", in_ready, 8'h20);
        step(1'b1, 8'hA4, d, MODE_RR, '0, 1'b1);
        check("rr_g2", in_ready, 8'h80);
        step(1'b1, 8'hA4, d, MODE_RR, '0, 1'b1);
        check("rr_g3_wrap", in_ready, 8'h04);
        step(1'b1, 8'hA4, d, MODE_RR, '0, 1'b1);
        check("rr_g4", in_ready, 8'h20);

        // Backpressure: output held for three cycles with inputs requesting.
        step(1'b1, '1, {$urandom, $urandom}, MODE_RR, '0, 1'b1);
        held = exp_q[exp_q.size() - 1].data;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, '1, {$urandom, $urandom}, MODE_RR, '0, 1'b0);
            check("bp_ready", in_ready, 8'h00);
            check("bp_hold", out_data, held);
        end

        // Reset while full and stalled: word discarded, pointer restarts.
        step(1'b0, '1, d, MODE_RR, '0, 1'b0);
        step(1'b1, '0, d, MODE_RR, '0, 1'b1);
        check("rst_full_cleared", out_valid, 1'b0);
        step(1'b1, '1, d, MODE_RR, '0, 1'b1);
        check("rst_rr_restart", in_ready, 8'h01);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(63) != 0), N'($urandom), {$urandom, $urandom},
                 logic'($urandom_range(1)), SW'($urandom), ($urandom_range(9) < 7));
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, '0, '0, MODE_RR, '0, 1'b1);
        end
        check("sb_drained", exp_q.size(), 0);

        // Five-channel build: illegal select, and round-robin wraps at 5.
        @(negedge clk);
        rst5_n    = 1'b0;
        in_valid5 = '1;
        in_data5  = {$urandom, $urandom};
        mode5     = MODE_FIXED;
        sel5      = 3'd6;
        out_ready5 = 1'b1;
        @(negedge clk);
        rst5_n = 1'b1;
        #1;
        check("n5_sel_oob", in_ready5, 5'h00);
        @(negedge clk);
        check("n5_oob_no_word", out_valid5, 1'b0);
        mode5 = MODE_RR;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("n5_rr_grant", in_ready5, 5'(1) << (k % 5));
            if (k > 0) begin
                check("n5_rr_chan", out_chan5, (k - 1) % 5);
            end
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
